// File: rtl/simon_game_core.sv
// simon_game_core: the Simon Says game engine. It generates a pseudo-random
// colour sequence, plays it back on the LEDs one round longer each time, and
// checks the player's button presses against it.
//
// Optional build feature: define SIMON_SPEEDUP_EN to shorten the LED hold time
// every four rounds (halving it each time, down to HOLD_CYCLES/8). With the
// macro undefined, every step is held for HOLD_CYCLES and no shift logic exists.
//
// Every output is a flop. led, win and lose are computed from the next-state
// values, so they line up with the state code on the same cycle.

module simon_game_core #(
    parameter int NUM_COLOURS    = 4,
    parameter int MAX_LEN        = 16,
    parameter int HOLD_CYCLES    = 1000000,
    parameter int GAP_CYCLES     = 250000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [7:0]                     seed,
    input  logic [NUM_COLOURS-1:0]         btn,
    output logic [NUM_COLOURS-1:0]         led,
    output logic [2:0]                     state,
    output logic [$clog2(MAX_LEN+1)-1:0]   round,
    output logic                           win,
    output logic                           lose
);

    // Bits per stored colour, round counter width and index width
    localparam int CW = (NUM_COLOURS > 2) ? $clog2(NUM_COLOURS) : 1;
    localparam int RW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

    // One timer serves hold, gap and input timeout, so size it for the largest
    localparam int TMAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    // 8-bit Fibonacci LFSR step, taps 7,5,4,3
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        lfsr_step = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Fold the low LFSR bits into the legal colour range 0..NUM_COLOURS-1
    function automatic logic [CW-1:0] colour_of(input logic [7:0] q);
        logic [7:0] raw;
        raw = {{(8-CW){1'b0}}, q[CW-1:0]};
        if (raw >= 8'(NUM_COLOURS)) begin
            colour_of = CW'(raw - 8'(NUM_COLOURS));
        end else begin
            colour_of = CW'(raw);
        end
    endfunction

    // Decode a stored colour into its one-hot LED/button pattern
    function automatic logic [NUM_COLOURS-1:0] onehot(input logic [CW-1:0] c);
        onehot = {NUM_COLOURS{1'b0}};
        for (int i = 0; i < NUM_COLOURS; i++) begin
            onehot[i] = (c == CW'(i));
        end
    endfunction

    // Registers
    state_t                 state_q, state_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [RW-1:0]          round_q, round_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_COLOURS-1:0] btn_prev_q;
    logic [NUM_COLOURS-1:0] led_q, led_d;
    logic                   win_q, win_d;
    logic                   lose_q, lose_d;
    logic [CW-1:0]          seq_q [MAX_LEN];

    // Helper signals
    logic                   seq_we_s;
    logic [CW-1:0]          colour_s;
    logic [RW-1:0]          round_m1_s;
    logic                   idx_at_end_s;
    logic                   press_s;
    logic                   btn_ok_s;
    logic [TW-1:0]          hold_last_s;

    assign colour_s     = colour_of(lfsr_q);
    assign round_m1_s   = round_q - RW'(1'b1);
    assign idx_at_end_s = (RW'(idx_q) == round_m1_s);

    // A press is the rising edge of "any button down"; holding produces one event
    assign press_s  = (btn_prev_q == {NUM_COLOURS{1'b0}}) && (btn != {NUM_COLOURS{1'b0}});
    // Correct only if exactly one button is down and it matches the expected colour
    assign btn_ok_s = ((btn & (btn - NUM_COLOURS'(1'b1))) == {NUM_COLOURS{1'b0}})
                   && (btn == onehot(seq_q[idx_q]));

`ifdef SIMON_SPEEDUP_EN
    logic [RW-1:0] speed_band_s;
    logic [1:0]    hold_shift_s;

    // Pick the hold shift: one extra halving every four rounds, capped at three
    always_comb begin
        speed_band_s = round_m1_s >> 2;
        if (speed_band_s > RW'(2'd3)) begin
            hold_shift_s = 2'd3;
        end else begin
            hold_shift_s = speed_band_s[1:0];
        end
        hold_last_s = TW'(HOLD_CYCLES >> hold_shift_s) - TW'(1'b1);
    end
`else
    assign hold_last_s = TW'(HOLD_CYCLES - 1);
`endif

    // State register plus all datapath counters, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 8'h00;
            idx_q      <= {IW{1'b0}};
            round_q    <= {RW{1'b0}};
            timer_q    <= {TW{1'b0}};
            btn_prev_q <= {NUM_COLOURS{1'b0}};
            led_q      <= {NUM_COLOURS{1'b0}};
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            round_q    <= round_d;
            timer_q    <= timer_d;
            btn_prev_q <= btn;
            led_q      <= led_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    // Sequence memory; always fully rewritten in GEN before it is read
    always_ff @(posedge clk) begin
        if (seq_we_s) begin
            seq_q[idx_q] <= colour_s;
        end
    end

    // Next-state and counter updates
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        idx_d    = idx_q;
        round_d  = round_q;
        timer_d  = timer_q;
        seq_we_s = 1'b0;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_d = S_GEN;
                    lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
                    idx_d   = {IW{1'b0}};
                    round_d = {RW{1'b0}};
                    timer_d = {TW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_GEN: begin
                seq_we_s = 1'b1;
                lfsr_d   = lfsr_step(lfsr_q);
                if (idx_q == IW'(MAX_LEN - 1)) begin
                    state_d = S_SHOW_ON;
                    idx_d   = {IW{1'b0}};
                    round_d = RW'(1'b1);
                    timer_d = {TW{1'b0}};
                end else begin
                    idx_d = idx_q + IW'(1'b1);
                end
            end
            S_SHOW_ON: begin
                if (timer_q == hold_last_s) begin
                    state_d = S_SHOW_OFF;
                    timer_d = {TW{1'b0}};
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end
            S_SHOW_OFF: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    timer_d = {TW{1'b0}};
                    if (idx_at_end_s) begin
                        state_d = S_INPUT;
                        idx_d   = {IW{1'b0}};
                    end else begin
                        state_d = S_SHOW_ON;
                        idx_d   = idx_q + IW'(1'b1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end
            S_INPUT: begin
                // A press on the timeout cycle takes priority over the timeout
                if (press_s) begin
                    timer_d = {TW{1'b0}};
                    if (!btn_ok_s) begin
                        state_d = S_LOSE;
                    end else if (!idx_at_end_s) begin
                        idx_d = idx_q + IW'(1'b1);
                    end else if (round_q == RW'(MAX_LEN)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_SHOW_ON;
                        round_d = round_q + RW'(1'b1);
                        idx_d   = {IW{1'b0}};
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_LOSE;
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so the registered outputs align with state
    always_comb begin
        led_d  = {NUM_COLOURS{1'b0}};
        win_d  = 1'b0;
        lose_d = 1'b0;
        case (state_d)
            S_SHOW_ON: begin
                led_d = onehot(seq_q[idx_d]);
            end
            S_INPUT: begin
                led_d = btn;
            end
            S_WIN: begin
                led_d = {NUM_COLOURS{1'b1}};
                win_d = 1'b1;
            end
            S_LOSE: begin
                led_d  = onehot(seq_q[idx_d]);
                lose_d = 1'b1;
            end
            default: begin
                led_d = {NUM_COLOURS{1'b0}};
            end
        endcase
    end

    assign led   = led_q;
    assign state = state_q;
    assign round = round_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule

// File: tb/tb_simon_game_core.sv
// Directed bench for simon_game_core with NUM_COLOURS=4, MAX_LEN=4, HOLD=3,
// GAP=2, TIMEOUT=20. Expected colour sequences are hand-computed from the LFSR:
//   seed 0xA5 -> colours 1,2,1,2 ; seed 0x01 (and 0x00) -> colours 1,2,0,0.

module tb_simon_game_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] seed;
    logic [3:0] btn;
    logic [3:0] led;
    logic [2:0] state;
    logic [2:0] round;
    logic       win;
    logic       lose;

    int total = 0;
    int bad   = 0;

    logic [3:0] oh [4];

    always #5 clk = ~clk;

    simon_game_core #(
        .NUM_COLOURS   (4),
        .MAX_LEN       (4),
        .HOLD_CYCLES   (3),
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .seed (seed),
        .btn  (btn),
        .led  (led),
        .state(state),
        .round(round),
        .win  (win),
        .lose (lose)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a game; returns on the first SHOW_ON cycle
    task automatic start_game(input logic [7:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("gen_round0", 32'(round), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("gen_state", 32'(state), 32'd1);
            tick();
        end
    endtask

    // Watch the display of round n; returns on the first INPUT cycle
    task automatic show_round(input int n);
        chk("show_round", 32'(round), 32'(n));
        for (int i = 0; i < n; i++) begin
            for (int h = 0; h < 3; h++) begin
                chk("show_on_state", 32'(state), 32'd2);
                chk("show_on_led", 32'(led), 32'(oh[i]));
                tick();
            end
            for (int g = 0; g < 2; g++) begin
                chk("show_off_state", 32'(state), 32'd3);
                chk("show_off_led", 32'(led), 32'd0);
                tick();
            end
        end
        chk("input_entry", 32'(state), 32'd4);
        chk("input_round", 32'(round), 32'(n));
    endtask

    // Press the correct colours for round n
    task automatic play_round(input int n);
        for (int i = 0; i < n; i++) begin
            btn = oh[i];
            tick();
            btn = 4'b0000;
            if (i < n - 1) begin
                chk("press_state", 32'(state), 32'd4);
                chk("press_echo", 32'(led), 32'(oh[i]));
                tick();
            end else begin
                if (n == 4) begin
                    chk("win_state", 32'(state), 32'd5);
                    chk("win_flag", 32'(win), 32'd1);
                    chk("win_led", 32'(led), 32'hF);
                    chk("win_round", 32'(round), 32'd4);
                    chk("win_lose", 32'(lose), 32'd0);
                end else begin
                    chk("next_round_state", 32'(state), 32'd2);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        seed  = 8'h00;
        btn   = 4'b0000;
        oh[0] = 4'b0010; oh[1] = 4'b0100; oh[2] = 4'b0010; oh[3] = 4'b0100;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_hold", 32'(state), 32'd0);
        end

        // Reset in the middle of SHOW_ON
        start_game(8'hA5);
        chk("pre_rst_state", 32'(state), 32'd2);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_led", 32'(led), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_round", 32'(round), 32'd0);
        chk("mid_rst_win", 32'(win), 32'd0);
        chk("mid_rst_lose", 32'(lose), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_rst_idle", 32'(state), 32'd0);

        // Full winning game, seed 0xA5
        start_game(8'hA5);
        for (int r = 1; r <= 4; r++) begin
            show_round(r);
            play_round(r);
        end

        // Wrong colour in round 2 (start accepted from WIN)
        start_game(8'hA5);
        show_round(1);
        play_round(1);
        show_round(2);
        btn = 4'b0010;
        tick();
        btn = 4'b0000;
        tick();
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        chk("wrong_state", 32'(state), 32'd6);
        chk("wrong_lose", 32'(lose), 32'd1);
        chk("wrong_round", 32'(round), 32'd2);
        chk("wrong_led", 32'(led), 32'h4);
        chk("wrong_win", 32'(win), 32'd0);

        // Two buttons at once (start accepted from LOSE)
        start_game(8'hA5);
        show_round(1);
        btn = 4'b0011;
        tick();
        btn = 4'b0000;
        chk("multi_state", 32'(state), 32'd6);
        chk("multi_led", 32'(led), 32'h2);
        chk("multi_round", 32'(round), 32'd1);

        // Input timeout: LOSE exactly 20 cycles after INPUT entry
        start_game(8'hA5);
        show_round(1);
        for (int j = 1; j < 20; j++) begin
            tick();
            chk("timeout_wait", 32'(state), 32'd4);
        end
        tick();
        chk("timeout_state", 32'(state), 32'd6);
        chk("timeout_lose", 32'(lose), 32'd1);

        // Held button counts once
        start_game(8'hA5);
        show_round(1);
        play_round(1);
        show_round(2);
        btn = 4'b0010;
        for (int j = 0; j < 10; j++) begin
            tick();
        end
        chk("hold_state", 32'(state), 32'd4);
        chk("hold_led", 32'(led), 32'h2);
        btn = 4'b0000;
        tick();
        btn = 4'b0100;
        tick();
        btn = 4'b0000;
        chk("hold_next_state", 32'(state), 32'd2);
        chk("hold_next_round", 32'(round), 32'd3);

        // Seed 0x00 behaves as seed 0x01
        oh[0] = 4'b0010; oh[1] = 4'b0100; oh[2] = 4'b0001; oh[3] = 4'b0001;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start_game(8'h00);
        for (int r = 1; r <= 4; r++) begin
            show_round(r);
            play_round(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
